// File: rtl/fpga_rst_seq.sv
// Power-on reset sequencer: waits for a stable PLL lock, then releases N_RST
// reset outputs one at a time, HOLD_CYC cycles apart, and drops back on lock loss.
module fpga_rst_seq #(
    parameter int SYNC_STAGES     = 2,
    parameter int LOCK_STABLE_CYC = 1024,
    parameter int HOLD_CYC        = 16,
    parameter int N_RST           = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pll_locked,
    output logic [N_RST-1:0] rst_out,
    output logic             sys_ready,
    output logic [7:0]       lock_loss_cnt,
    output logic [2:0]       state_o
);

    typedef enum logic [2:0] {
        S_RESET     = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4
    } state_t;

    localparam logic [N_RST-1:0] ALL_ON     = '1;
    localparam logic [15:0]      STABLE_END = 16'(LOCK_STABLE_CYC - 1);
    localparam logic [7:0]       HOLD_END   = 8'(HOLD_CYC - 1);
    localparam logic [2:0]       LAST_STAGE = 3'(N_RST - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   lock_s;

    state_t           state_reg, state_next;
    logic [15:0]      stab_cnt_reg, stab_cnt_next;
    logic [7:0]       hold_cnt_reg, hold_cnt_next;
    logic [2:0]       stage_reg, stage_next;
    logic [N_RST-1:0] rst_out_reg, rst_out_next;
    logic             ready_reg, ready_next;
    logic [7:0]       loss_cnt_reg, loss_cnt_next;

    // pll_locked is asynchronous; nothing but this chain may look at it.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign lock_s = sync_reg[SYNC_STAGES-1];

    always_comb begin
        state_next    = state_reg;
        stab_cnt_next = stab_cnt_reg;
        hold_cnt_next = hold_cnt_reg;
        stage_next    = stage_reg;
        rst_out_next  = rst_out_reg;
        ready_next    = ready_reg;
        loss_cnt_next = loss_cnt_reg;

        case (state_reg)
            S_RESET: begin
                state_next   = S_WAIT_LOCK;
                rst_out_next = ALL_ON;
                ready_next   = 1'b0;
            end
            S_WAIT_LOCK: begin
                rst_out_next = ALL_ON;
                ready_next   = 1'b0;
                if (lock_s) begin
                    state_next    = S_STABLE;
                    stab_cnt_next = '0;
                end
            end
            S_STABLE: begin
                if (lock_s) begin
                    if (stab_cnt_reg == STABLE_END) begin
                        state_next    = S_RELEASE;
                        rst_out_next  = ALL_ON << 1;
                        hold_cnt_next = '0;
                        stage_next    = '0;
                    end else begin
                        stab_cnt_next = stab_cnt_reg + 16'd1;
                    end
                end
            end
            S_RELEASE: begin
                if (lock_s) begin
                    if (hold_cnt_reg == HOLD_END) begin
                        hold_cnt_next = '0;
                        if (stage_reg == LAST_STAGE) begin
                            state_next = S_RUN;
                            ready_next = 1'b1;
                        end else begin
                            // Shifting a zero in from the bottom keeps release strictly in order.
                            stage_next   = stage_reg + 3'd1;
                            rst_out_next = rst_out_reg << 1;
                        end
                    end else begin
                        hold_cnt_next = hold_cnt_reg + 8'd1;
                    end
                end
            end
            S_RUN: begin
                rst_out_next = '0;
                ready_next   = 1'b1;
            end
            default: begin
                state_next = S_RESET;
            end
        endcase

        // Lock loss overrides whatever the active states decided above.
        if (!lock_s && (state_reg == S_STABLE || state_reg == S_RELEASE || state_reg == S_RUN)) begin
            state_next    = S_WAIT_LOCK;
            rst_out_next  = ALL_ON;
            ready_next    = 1'b0;
            stab_cnt_next = '0;
            hold_cnt_next = '0;
            stage_next    = '0;
            if (loss_cnt_reg != 8'hFF) begin
                loss_cnt_next = loss_cnt_reg + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_RESET;
            stab_cnt_reg <= '0;
            hold_cnt_reg <= '0;
            stage_reg    <= '0;
            rst_out_reg  <= ALL_ON;
            ready_reg    <= 1'b0;
            loss_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            stab_cnt_reg <= stab_cnt_next;
            hold_cnt_reg <= hold_cnt_next;
            stage_reg    <= stage_next;
            rst_out_reg  <= rst_out_next;
            ready_reg    <= ready_next;
            loss_cnt_reg <= loss_cnt_next;
        end
    end

    assign rst_out       = rst_out_reg;
    assign sys_ready     = ready_reg;
    assign lock_loss_cnt = loss_cnt_reg;
    assign state_o       = state_reg;

endmodule
